// File: rtl/sdram_bist.sv
// sdram_bist -- built-in self-test engine for the full-page-burst SDRAM
// controller. Writes pattern bursts over f_addr = 0..addr_last (wrapping),
// reads them back, compares against the same pattern and reports
// error/word counts and pass/fail. A pass keeps cycling over the address
// range until at least RUN_CYCLES clocks have elapsed.
//
// Optional feature: define SDRAM_BIST_INJECT_EN to add the `inject` input.
// When latched high at start_wr, beat 0 of every write burst whose
// f_addr[3:0] == 0 has bit 0 inverted.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start_wr, start_rd   start a write / read-verify pass (IDLE only)
//   mode                 00 INC, 01 INV, 10 WALK, 11 LFSR (latched at start)
//   addr_last            last burst address of the range (latched at start)
//   rw, rw_en, f_addr    request interface to the controller
//   f2s_data             write data, consumed when f2s_data_valid is high
//   s2f_data(_valid)     read data from the controller
//   ready                controller idle
//   busy, done, pass     status: not idle, end-of-pass pulse, last read ok
//   err_cnt, word_cnt    mismatches / beats in the current or last pass
module sdram_bist #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15,
  parameter int BURST_LEN  = 512,
  parameter int RUN_CYCLES = 165_000_000,
  parameter int ERR_W      = 20,
  parameter int CNT_W      = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_last,
`ifdef SDRAM_BIST_INJECT_EN
  input  logic              inject,
`endif
  output logic              rw,
  output logic              rw_en,
  output logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f2s_data,
  input  logic              f2s_data_valid,
  input  logic [DATA_W-1:0] s2f_data,
  input  logic              s2f_data_valid,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0] BEAT_END = BEAT_W'(BURST_LEN);
  localparam logic [DATA_W-1:0] DW_VEC   = DATA_W'(DATA_W);
  localparam logic [CNT_W-1:0]  RUN_LIM  = CNT_W'(RUN_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    REQ_WR,
    REQ_RD,
    WR_BURST,
    RD_BURST
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] addr_last_q;
  logic [BEAT_W-1:0] beat;
  logic [15:0]       lfsr;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [DATA_W-1:0] expected;
  logic              burst_end;
  logic [ADDR_W-1:0] next_addr;

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a,
    input logic [BEAT_W-1:0] b,
    input logic [15:0]       l
  );
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] r;
    // Summing in DATA_W bits is the same as truncating the full sum.
    v = DATA_W'(a) + DATA_W'(b);
    case (m)
      2'b00:   r = v;
      2'b01:   r = ~v;
      2'b10:   r = DATA_W'(1) << (v % DW_VEC);
      default: r = DATA_W'(l);
    endcase
    return r;
  endfunction

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (shift towards bit 0).
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_seed(input logic [ADDR_W-1:0] a);
    logic [15:0] s;
    s = 16'(a) ^ 16'hACE1;
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  always_comb begin
    expected  = pattern(mode_q, f_addr, beat, lfsr);
    next_addr = (f_addr == addr_last_q) ? '0 : f_addr + ADDR_W'(1);
    burst_end = 1'b0;
    if (beat == BEAT_END) begin
      if (state == WR_BURST) burst_end = !f2s_data_valid;
      if (state == RD_BURST) burst_end = !s2f_data_valid;
    end
  end

`ifdef SDRAM_BIST_INJECT_EN
  logic inject_q;
  logic corrupt;
  assign corrupt  = inject_q && (state == WR_BURST) && (beat == '0) &&
                    (f_addr[3:0] == 4'h0);
  assign f2s_data = expected ^ {{(DATA_W-1){1'b0}}, corrupt};
`else
  assign f2s_data = expected;
`endif

  // The request strobe follows ready in the same cycle so the controller
  // sees it while it is still idle; everything else is registered.
  assign rw_en = ((state == REQ_WR) || (state == REQ_RD)) && ready;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= '0;
      addr_last_q <= '0;
      beat        <= '0;
      lfsr        <= '0;
      cyc_cnt     <= '0;
      f_addr      <= '0;
      rw          <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= '0;
      word_cnt    <= '0;
`ifdef SDRAM_BIST_INJECT_EN
      inject_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (start_wr || start_rd) begin
            f_addr      <= '0;
            word_cnt    <= '0;
            cyc_cnt     <= '0;
            mode_q      <= mode;
            addr_last_q <= addr_last;
            if (start_wr) begin
              state <= REQ_WR;
              rw    <= 1'b0;
`ifdef SDRAM_BIST_INJECT_EN
              inject_q <= inject;
`endif
            end else begin
              state   <= REQ_RD;
              rw      <= 1'b1;
              err_cnt <= '0;
              pass    <= 1'b0;
            end
          end
        end

        REQ_WR, REQ_RD: begin
          if (ready) begin
            beat  <= '0;
            lfsr  <= lfsr_seed(f_addr);
            state <= (state == REQ_WR) ? WR_BURST : RD_BURST;
          end
        end

        WR_BURST, RD_BURST: begin
          if (burst_end) begin
            if (cyc_cnt >= RUN_LIM) begin
              state <= IDLE;
              done  <= 1'b1;
              if (state == RD_BURST) pass <= (err_cnt == '0);
            end else begin
              f_addr <= next_addr;
              state  <= (state == WR_BURST) ? REQ_WR : REQ_RD;
            end
          end else if (beat < BEAT_END &&
                       ((state == WR_BURST && f2s_data_valid) ||
                        (state == RD_BURST && s2f_data_valid))) begin
            if (state == RD_BURST && s2f_data != expected && err_cnt != '1)
              err_cnt <= err_cnt + ERR_W'(1);
            beat <= beat + BEAT_W'(1);
            lfsr <= lfsr_step(lfsr);
            if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bist.sv
module tb_sdram_bist;

  localparam int DW = 16;
  localparam int AW = 15;
  localparam int BL = 8;
  localparam int RC = 200;
  localparam int EW = 20;
  localparam int CW = 37;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_wr, start_rd;
  logic [1:0]    mode;
  logic [AW-1:0] addr_last;
  logic          rw, rw_en;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f2s_data;
  logic          f2s_data_valid;
  logic [DW-1:0] s2f_data;
  logic          s2f_data_valid;
  logic          ready;
  logic          busy, done, pass;
  logic [EW-1:0] err_cnt;
  logic [CW-1:0] word_cnt;
`ifdef SDRAM_BIST_INJECT_EN
  logic          inject;
`endif

  always #5 clk = ~clk;

  sdram_bist #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .RUN_CYCLES(RC),
    .ERR_W(EW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_wr(start_wr), .start_rd(start_rd),
    .mode(mode), .addr_last(addr_last),
`ifdef SDRAM_BIST_INJECT_EN
    .inject(inject),
`endif
    .rw(rw), .rw_en(rw_en), .f_addr(f_addr),
    .f2s_data(f2s_data), .f2s_data_valid(f2s_data_valid),
    .s2f_data(s2f_data), .s2f_data_valid(s2f_data_valid),
    .ready(ready), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference pattern: beat `b` of the burst at address `a`.
  function automatic logic [15:0] ref_word(input int unsigned m,
                                           input int unsigned a,
                                           input int unsigned b);
    int unsigned v, s, fb;
    v = (a + b) & 32'hFFFF;
    case (m)
      0: return 16'(v);
      1: return 16'(~v);
      2: return 16'(32'd1 << (v % 16));
      default: begin
        s = (a & 32'hFFFF) ^ 32'hACE1;
        if (s == 0) s = 1;
        for (int unsigned k = 0; k < b; k++) begin
          fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
          s  = (s >> 1) | (fb << 15);
        end
        return 16'(s);
      end
    endcase
  endfunction

  // Controller model state, shared with the main sequence.
  logic [15:0] mem [0:63][0:7];
  int unsigned cur_mode, cur_last, exp_rw, inject_lat;
  int          req_idx, sb_err;
  bit          gaps_en, extra_en, corrupt_en, hit_abort;
  int          abort_beat = -1;

  // Behavioural SDRAM controller.
  initial begin : ctrl
    int unsigned a;
    logic        r;
    logic [15:0] e;
    int          g;
    bit          aborted;
    ready = 1'b1; f2s_data_valid = 1'b0; s2f_data_valid = 1'b0; s2f_data = '0;
    forever begin
      @(negedge clk);
      if (rw_en === 1'b1 && rst_n === 1'b1) begin
        a = int'(f_addr);
        r = rw;
        check_eq("req_rw", r, exp_rw);
        check_eq("req_addr", a, req_idx % (cur_last + 1));
        req_idx++;
        @(posedge clk); #1;
        ready = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < BL; i++) begin
          if (gaps_en) begin
            g = $urandom_range(0, 2);
            f2s_data_valid = 1'b0; s2f_data_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
          end
          if (r == 1'b0) begin
            f2s_data_valid = 1'b1;
            @(negedge clk);
            e = ref_word(cur_mode, a, i);
            if (inject_lat != 0 && i == 0 && (a % 16) == 0) e = e ^ 16'h0001;
            check_eq("wdata", f2s_data, e);
            mem[a % 64][i] = f2s_data;
          end else begin
            if (abort_beat == i) begin
              s2f_data_valid = 1'b0;
              hit_abort = 1'b1;
              aborted = 1'b1;
              break;
            end
            s2f_data = mem[a % 64][i];
            if (corrupt_en && a == 1 && i == 5) s2f_data = s2f_data ^ 16'h0010;
            if (s2f_data != ref_word(cur_mode, a, i)) sb_err++;
            s2f_data_valid = 1'b1;
          end
          @(posedge clk); #1;
        end
        if (r == 1'b1 && !aborted && extra_en && $urandom_range(0, 1) == 1) begin
          s2f_data = ~ref_word(cur_mode, a, BL);
          s2f_data_valid = 1'b1;
          @(posedge clk); #1;
        end
        f2s_data_valid = 1'b0;
        s2f_data_valid = 1'b0;
        ready = 1'b1;
      end
    end
  end

  task automatic run_pass(input bit wr, input bit rd, input int unsigned m,
                          input int unsigned last, input bit inj);
    int n;
    cur_mode = m; cur_last = last; exp_rw = wr ? 0 : 1;
    req_idx = 0; sb_err = 0;
    if (wr) begin
      inject_lat = inj;
      for (int unsigned x = 0; x < 64; x++)
        for (int unsigned y = 0; y < BL; y++) mem[x][y] = ref_word(m, x, y);
    end
`ifdef SDRAM_BIST_INJECT_EN
    inject = inj;
`endif
    mode = 2'(m); addr_last = AW'(last);
    start_wr = wr; start_rd = rd;
    @(posedge clk); #1;
    start_wr = 1'b0; start_rd = 1'b0;
    mode = 2'($urandom); addr_last = AW'($urandom_range(0, 40));
`ifdef SDRAM_BIST_INJECT_EN
    inject = 1'b0;
`endif
    @(negedge clk);
    check_eq("busy_after_start", busy, 1);
    repeat (4) @(posedge clk);
    #1 start_wr = 1'b1; start_rd = 1'b1;
    @(posedge clk); #1;
    start_wr = 1'b0; start_rd = 1'b0;
    n = 6;
    while (done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check_eq("done_seen", done, 1);
    check_eq("min_run_cycles", n >= RC, 1);
    check_eq("word_cnt", word_cnt, 64'(req_idx) * BL);
    if (rd && !wr) begin
      check_eq("err_cnt", err_cnt, sb_err);
      check_eq("pass", pass, sb_err == 0);
    end
    @(negedge clk);
    check_eq("done_pulse", done, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0; start_wr = 1'b0; start_rd = 1'b0;
    mode = 2'b11; addr_last = AW'(7);
    inject_lat = 0; gaps_en = 1'b1; extra_en = 1'b1; corrupt_en = 1'b0;
    hit_abort = 1'b0; cur_mode = 0; cur_last = 0; exp_rw = 0;
    req_idx = 0; sb_err = 0;
`ifdef SDRAM_BIST_INJECT_EN
    inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err", err_cnt, 0);
    check_eq("rst_words", word_cnt, 0);
    check_eq("rst_rw_en", rw_en, 0);
    check_eq("rst_f_addr", f_addr, 0);
    check_eq("rst_rw", rw, 0);
    check_eq("rst_f2s", f2s_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // INC write/read over 0..3.
    run_pass(1, 0, 0, 3, 0);
    run_pass(0, 1, 0, 3, 0);
    check_eq("inc_pass", pass, 1);
    check_eq("inc_err", err_cnt, 0);

    // LFSR with one corrupted read beat per visit of address 1.
    run_pass(1, 0, 3, 3, 0);
    corrupt_en = 1'b1;
    run_pass(0, 1, 3, 3, 0);
    corrupt_en = 1'b0;
    check_eq("lfsr_pass", pass, 0);
    check_eq("lfsr_err_seen", err_cnt != 0, 1);

    // Simultaneous starts -> write; WALK over a two-address wrap.
    run_pass(1, 1, 2, 1, 0);
    run_pass(0, 1, 2, 1, 0);
    check_eq("walk_pass", pass, 1);

    // Reset in the middle of a read burst.
    run_pass(1, 0, 1, 2, 0);
    cur_mode = 0; cur_last = 2; exp_rw = 1; req_idx = 0; sb_err = 0;
    abort_beat = 4; hit_abort = 1'b0;
    mode = 2'b00; addr_last = AW'(2); start_rd = 1'b1;
    @(posedge clk); #1 start_rd = 1'b0;
    n = 0;
    while (!hit_abort && n < 500) begin @(negedge clk); n++; end
    check_eq("abort_reached", hit_abort, 1);
    check_eq("abort_err_before", err_cnt, sb_err);
    check_eq("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rw_en", rw_en, 0);
    check_eq("abort_err", err_cnt, 0);
    check_eq("abort_words", word_cnt, 0);
    abort_beat = -1; hit_abort = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(0, 1, 1, 2, 0);
    check_eq("after_abort_pass", pass, 1);

`ifdef SDRAM_BIST_INJECT_EN
    gaps_en = 1'b0; extra_en = 1'b0;
    run_pass(1, 0, 0, 31, 1);
    run_pass(0, 1, 0, 31, 0);
    check_eq("inj_no_wrap", req_idx <= 32, 1);
    check_eq("inj_err", err_cnt, 2);
    check_eq("inj_pass", pass, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_bist.md
Name: sdram_bist

Overview:
- Parametrised built-in self-test engine for the full-page-burst SDRAM controller.
- Generates write bursts over a configurable address range, reads them back, and compares against a selectable data pattern.
- Reports error count, words transferred and pass/fail.
- Sits between board-level keys/LEDs and `sdram_controller`, replacing the fixed 16-bit, single-pattern test harness.

Parameters:
- DATA_W, 16, SDRAM word width (f2s_data/s2f_data).
- ADDR_W, 15, width of burst address f_addr.
- BURST_LEN, 512, beats per burst; must match the controller page size.
- RUN_CYCLES, 165_000_000, minimum test duration in clk cycles.
- ERR_W, 20, error counter width.
- CNT_W, 37, word and cycle counter width.

Ports:
- clk  in  1  system clock (SDRAM controller clock)
- rst_n  in  1  asynchronous active-low reset
- start_wr  in  1  level/pulse; starts a write pass when idle
- start_rd  in  1  level/pulse; starts a read-verify pass when idle
- mode  in  2  pattern: 00 INC, 01 INV, 10 WALK, 11 LFSR; latched at start
- addr_last  in  ADDR_W  last burst address of the range; latched at start
- rw  out  1  1 = read, 0 = write (to controller)
- rw_en  out  1  one-cycle request strobe (to controller)
- f_addr  out  ADDR_W  burst address (to controller)
- f2s_data  out  DATA_W  write data
- f2s_data_valid  in  1  controller consumes f2s_data at the next rising edge
- s2f_data  in  DATA_W  read data
- s2f_data_valid  in  1  s2f_data valid this cycle
- ready  in  1  controller idle
- busy  out  1  engine not in IDLE
- done  out  1  one-cycle pulse when a pass finishes
- pass  out  1  1 = last read pass finished with zero errors
- err_cnt  out  ERR_W  mismatches in current/last read pass
- word_cnt  out  CNT_W  beats transferred in current/last pass

Behaviour:
- Reset: async reset forces IDLE from any state, including mid-burst. All outputs, counters and latched mode/addr_last are cleared to 0.
- States and transitions:
  - IDLE: start_wr → REQ_WR; start_rd → REQ_RD. Both asserted together → start_wr wins. Starts in any other state are ignored.
  - On leaving IDLE: f_addr = 0, word_cnt = 0, cycle counter = 0, mode and addr_last latched. A read start also clears err_cnt and pass.
  - REQ_WR / REQ_RD: wait for ready. In the cycle ready=1, drive rw_en = 1 with rw = 0 (write) or rw = 1 (read), clear the beat counter, go to WR_BURST / RD_BURST. rw_en is 0 in every other cycle.
- WR_BURST:
  - f2s_data is combinational from (f_addr, beat, LFSR state) so it is valid in the same cycle as f2s_data_valid.
  - Each cycle with f2s_data_valid=1: beat++, word_cnt++.
  - End of burst: beat == BURST_LEN with f2s_data_valid = 0.
- RD_BURST:
  - Each cycle with s2f_data_valid=1 and beat < BURST_LEN: compare s2f_data with the expected pattern; on mismatch err_cnt++. Then beat++, word_cnt++.
  - Valid beats with beat ≥ BURST_LEN are ignored.
  - End of burst: beat == BURST_LEN with s2f_data_valid = 0.
- At end of burst:
  - If cycle counter ≥ RUN_CYCLES: go to IDLE, pulse done; on a read pass set pass = (err_cnt == 0).
  - Otherwise: f_addr = (f_addr == addr_last) ? 0 : f_addr + 1, then return to REQ_WR / REQ_RD.
- Cycle counter: increments every non-IDLE cycle.
- Saturation: err_cnt, word_cnt and the cycle counter all saturate at all-ones and never wrap.
- Patterns, with v = (f_addr + beat) truncated/zero-extended to DATA_W:
  - INC: v.
  - INV: ~v.
  - WALK: 1 << (v mod DATA_W).
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seeded at the start of each burst with f_addr XOR 16'hACE1 (seed 0 is replaced by 1). Advances once per consumed/compared beat. Data is the LFSR state zero-extended or truncated to DATA_W.
  - Write and read use the identical function.
- busy = (state != IDLE).

Optional Feature:
- Macro: SDRAM_BIST_INJECT_EN.
- Defined: adds input port `inject` (1 bit), latched at start_wr. When the latched value is 1, beat 0 of every write burst with f_addr[3:0] == 0 has bit 0 inverted. Expected read errors = number of such bursts written.
- Undefined: no inject port, no data corruption.

Test Plan:
- Bench settings: BURST_LEN = 8, RUN_CYCLES = 200, behavioural controller model.
- INC write then read, addr_last = 3: f2s_data sequence for f_addr = 2 is 2..9; read pass → done pulse, pass = 1, err_cnt = 0, word_cnt a multiple of 8.
- LFSR mode with model corrupting one read beat (f_addr = 1, beat = 5): err_cnt = 1 per occurrence, pass = 0.
- start_wr and start_rd asserted in the same cycle → write pass only (rw = 0 on the first rw_en); starts during busy are ignored.
- rst_n low mid-RD_BURST (beat 4) → same cycle: busy = 0, rw_en = 0, err_cnt = 0; the next start_rd begins at f_addr = 0.
- Address wrap: addr_last = 1 with a long run → f_addr sequence 0,1,0,1,…
- Extra model beat: a 9th s2f_data_valid beat is ignored.
- With SDRAM_BIST_INJECT_EN defined, inject = 1 and addr_last = 31: read pass with no wrap gives err_cnt = 2 (f_addr 0 and 16).
